// File: rtl/uart_gonderim_kuyrugu.sv
// uart_gonderim_kuyrugu: transmit FIFO feeding the UART transmitter, with a held output byte,
// fill level, low-water interrupt and sticky overflow flag.
module uart_gonderim_kuyrugu #(
  parameter int DERINLIK       = 16,
  parameter int VERI_GENISLIGI = 8
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          yaz_gecerli_i,
  input  logic [VERI_GENISLIGI-1:0]     yaz_veri_i,
  output logic                          yaz_hazir_o,
  input  logic                          temizle_i,
  output logic                          veri_gecerli_o,
  input  logic                          consume_i,
  output logic [VERI_GENISLIGI-1:0]     veri_o,
  output logic [$clog2(DERINLIK):0]     doluluk_o,
  output logic                          dolu_o,
  output logic                          bos_o,
  input  logic [$clog2(DERINLIK):0]     esik_i,
  output logic                          esik_kesme_o,
  output logic                          tasma_o
);
  localparam int AW = $clog2(DERINLIK);
  localparam int CW = AW + 1;

  logic [VERI_GENISLIGI-1:0] mem [DERINLIK];
  logic [AW-1:0]             yaz_ptr, oku_ptr;
  logic [CW-1:0]             sayac;
  logic                      yaz_ok, oku_ok;

  // Full/empty come only from the registered count, so consume_i never reaches yaz_hazir_o.
  assign dolu_o         = sayac == CW'(DERINLIK);
  assign bos_o          = sayac == '0;
  assign yaz_hazir_o    = !dolu_o;
  assign veri_gecerli_o = !bos_o;
  assign doluluk_o      = sayac;
  assign esik_kesme_o   = (sayac <= esik_i) || (esik_i >= CW'(DERINLIK));
  assign yaz_ok         = yaz_gecerli_i && !dolu_o;
  assign oku_ok         = consume_i && !bos_o;

  always_ff @(posedge clk_i)
    if (yaz_ok && !temizle_i) mem[yaz_ptr] <= yaz_veri_i;

  // veri_o survives a flush so a byte already on the line finishes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      sayac   <= '0;
      veri_o  <= '0;
      tasma_o <= 1'b0;
    end else if (temizle_i) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      sayac   <= '0;
      tasma_o <= 1'b0;
    end else begin
      if (yaz_ok) yaz_ptr <= yaz_ptr + AW'(1);
      if (yaz_gecerli_i && dolu_o) tasma_o <= 1'b1;
      if (oku_ok) begin
        veri_o  <= mem[oku_ptr];
        oku_ptr <= oku_ptr + AW'(1);
      end
      sayac <= sayac + CW'(yaz_ok) - CW'(oku_ok);
    end
  end
endmodule

// File: tb/tb_uart_gonderim_kuyrugu.sv
// tb_uart_gonderim_kuyrugu: directed vector table plus hand-written overflow, flush,
// wrap-around and asynchronous reset sequences for the UART transmit FIFO.
module tb_uart_gonderim_kuyrugu;
  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       yaz_gecerli_i, temizle_i, consume_i;
  logic [7:0] yaz_veri_i;
  logic       yaz_hazir_o, veri_gecerli_o, dolu_o, bos_o, esik_kesme_o, tasma_o;
  logic [7:0] veri_o;
  logic [4:0] doluluk_o, esik_i;
  int         total = 0;
  int         bad = 0;

  uart_gonderim_kuyrugu #(.DERINLIK(16), .VERI_GENISLIGI(8)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .yaz_gecerli_i(yaz_gecerli_i), .yaz_veri_i(yaz_veri_i),
    .yaz_hazir_o(yaz_hazir_o), .temizle_i(temizle_i), .veri_gecerli_o(veri_gecerli_o),
    .consume_i(consume_i), .veri_o(veri_o), .doluluk_o(doluluk_o), .dolu_o(dolu_o),
    .bos_o(bos_o), .esik_i(esik_i), .esik_kesme_o(esik_kesme_o), .tasma_o(tasma_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       yaz;
    logic [7:0] d;
    logic       cons;
    logic       tem;
    logic [4:0] esik;
    logic [4:0] e_cnt;
    logic [7:0] e_veri;
    logic       e_tasma;
    logic       e_kesme;
  } vec_t;

  vec_t v [22];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic yaz, input logic [7:0] d, input logic cons, input logic tem);
    yaz_gecerli_i = yaz;
    yaz_veri_i    = d;
    consume_i     = cons;
    temizle_i     = tem;
    @(posedge clk_i);
    #1;
    yaz_gecerli_i = 1'b0;
    consume_i     = 1'b0;
    temizle_i     = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_veri;
    logic       pop;
    v[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 5'd0,  5'd1, 8'h00, 1'b0, 1'b0};
    v[1]  = '{1'b1, 8'h42, 1'b0, 1'b0, 5'd0,  5'd2, 8'h00, 1'b0, 1'b0};
    v[2]  = '{1'b1, 8'h43, 1'b0, 1'b0, 5'd0,  5'd3, 8'h00, 1'b0, 1'b0};
    v[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0,  5'd2, 8'h41, 1'b0, 1'b0};
    v[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0,  5'd1, 8'h42, 1'b0, 1'b0};
    v[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0,  5'd0, 8'h43, 1'b0, 1'b1};
    v[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0,  5'd0, 8'h43, 1'b0, 1'b1};
    v[7]  = '{1'b1, 8'hAA, 1'b1, 1'b0, 5'd0,  5'd1, 8'h43, 1'b0, 1'b0};
    v[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0,  5'd0, 8'hAA, 1'b0, 1'b1};
    v[9]  = '{1'b1, 8'h01, 1'b0, 1'b0, 5'd4,  5'd1, 8'hAA, 1'b0, 1'b1};
    v[10] = '{1'b1, 8'h02, 1'b0, 1'b0, 5'd4,  5'd2, 8'hAA, 1'b0, 1'b1};
    v[11] = '{1'b1, 8'h03, 1'b0, 1'b0, 5'd4,  5'd3, 8'hAA, 1'b0, 1'b1};
    v[12] = '{1'b1, 8'h04, 1'b0, 1'b0, 5'd4,  5'd4, 8'hAA, 1'b0, 1'b1};
    v[13] = '{1'b1, 8'h05, 1'b0, 1'b0, 5'd4,  5'd5, 8'hAA, 1'b0, 1'b0};
    v[14] = '{1'b1, 8'h06, 1'b0, 1'b0, 5'd4,  5'd6, 8'hAA, 1'b0, 1'b0};
    v[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd4,  5'd5, 8'h01, 1'b0, 1'b0};
    v[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd4,  5'd4, 8'h02, 1'b0, 1'b1};
    v[17] = '{1'b1, 8'h07, 1'b1, 1'b0, 5'd4,  5'd4, 8'h03, 1'b0, 1'b1};
    v[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd16, 5'd4, 8'h03, 1'b0, 1'b1};
    v[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd3,  5'd4, 8'h03, 1'b0, 1'b0};
    v[20] = '{1'b1, 8'h55, 1'b1, 1'b1, 5'd0,  5'd0, 8'h03, 1'b0, 1'b1};
    v[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0,  5'd0, 8'h03, 1'b0, 1'b1};

    rstn_i = 1'b0; yaz_gecerli_i = 1'b0; yaz_veri_i = 8'h00;
    consume_i = 1'b0; temizle_i = 1'b0; esik_i = 5'd0;
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("reset bos", bos_o, 1);
    chk("reset hazir", yaz_hazir_o, 1);
    chk("reset gecerli", veri_gecerli_o, 0);
    chk("reset doluluk", doluluk_o, 0);
    chk("reset tasma", tasma_o, 0);
    chk("reset veri", veri_o, 0);

    for (int i = 0; i < 22; i++) begin
      esik_i = v[i].esik;
      step(v[i].yaz, v[i].d, v[i].cons, v[i].tem);
      chk($sformatf("vec%0d doluluk", i), doluluk_o, v[i].e_cnt);
      chk($sformatf("vec%0d veri", i), veri_o, v[i].e_veri);
      chk($sformatf("vec%0d tasma", i), tasma_o, v[i].e_tasma);
      chk($sformatf("vec%0d kesme", i), esik_kesme_o, v[i].e_kesme);
      chk($sformatf("vec%0d bos", i), bos_o, v[i].e_cnt == 5'd0);
      chk($sformatf("vec%0d gecerli", i), veri_gecerli_o, v[i].e_cnt != 5'd0);
    end

    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 14) chk("fill15 dolu", dolu_o, 0);
    end
    chk("full dolu", dolu_o, 1);
    chk("full hazir", yaz_hazir_o, 0);
    chk("full doluluk", doluluk_o, 16);
    chk("full tasma", tasma_o, 0);
    step(1'b1, 8'h10, 1'b0, 1'b0);
    chk("ovf tasma", tasma_o, 1);
    chk("ovf doluluk", doluluk_o, 16);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("full wr+pop doluluk", doluluk_o, 15);
    chk("full wr+pop veri", veri_o, 8'h00);
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk($sformatf("drain%0d veri", i), veri_o, 8'(i));
    end
    chk("drain bos", bos_o, 1);
    chk("drain tasma sticky", tasma_o, 1);

    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    chk("fill10 doluluk", doluluk_o, 10);
    step(1'b1, 8'h99, 1'b0, 1'b1);
    chk("flush doluluk", doluluk_o, 0);
    chk("flush tasma", tasma_o, 0);
    chk("flush veri kept", veri_o, 8'h0F);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush wr discarded", veri_o, 8'h0F);

    exp_veri = veri_o;
    for (int i = 0; i < 40; i++) begin
      pop = q.size() >= 3;
      step(1'b1, 8'(8'h80 + i), pop, 1'b0);
      if (pop) exp_veri = q.pop_front();
      q.push_back(8'(8'h80 + i));
      chk($sformatf("wrap%0d veri", i), veri_o, exp_veri);
      chk($sformatf("wrap%0d doluluk", i), doluluk_o, q.size());
    end
    for (int n = 0; n < 20 && q.size() > 0; n++) begin
      exp_veri = q.pop_front();
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk($sformatf("wrapdrain%0d veri", n), veri_o, exp_veri);
    end
    chk("wrap end bos", bos_o, 1);

    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b1, 8'h5B, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre-rst veri", veri_o, 8'h5A);
    rstn_i = 1'b0;
    #1;
    chk("async rst doluluk", doluluk_o, 0);
    chk("async rst veri", veri_o, 0);
    chk("async rst bos", bos_o, 1);
    @(posedge clk_i);
    #1 rstn_i = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
